// File: rtl/branch_resolve_unit.sv
// rtl/branch_resolve_unit.sv - update-side driver for the sat_count branch predictor
//
// Purpose:
//   Holds each fetched branch's predicted direction in an in-order queue, matches the
//   oldest entry against the outcome resolved by execute and drives the predictor's
//   branch/taken update pulse one cycle later. A mispredict clears the whole queue
//   (all younger entries are wrong-path) and closes the fetch side for FLUSH_CYCLES.
//
// Optional feature:
//   BRU_STATS_EN - when defined, adds saturating stat_branches / stat_mispred counters
//                  and their ports. When undefined neither the ports nor the logic exist.
//
// Ports:
//   clk, reset          rising-edge clock, synchronous active-high reset
//   pred_valid/taken    fetch-side predicted branch; accepted when pred_ready is high
//   pred_ready          queue accepts a prediction this cycle
//   res_valid/taken     execute-side outcome for the oldest queued branch
//   branch/taken        registered update pulse/direction to the predictor
//   mispredict          registered pulse, coincident with branch
//   count               current queue occupancy
//   err_underflow       sticky: an outcome arrived while the queue was empty
//   stat_branches       resolved branches (BRU_STATS_EN only)
//   stat_mispred        mispredicted branches (BRU_STATS_EN only)

module branch_resolve_unit #(
   parameter int DEPTH        = 4,
   parameter int FLUSH_CYCLES = 2,
   parameter int STAT_W       = 16
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       pred_valid,
   input  logic                       pred_taken,
   output logic                       pred_ready,
   input  logic                       res_valid,
   input  logic                       res_taken,
   output logic                       branch,
   output logic                       taken,
   output logic                       mispredict,
   output logic [$clog2(DEPTH):0]     count,
   output logic                       err_underflow
`ifdef BRU_STATS_EN
   ,
   output logic [STAT_W-1:0]          stat_branches,
   output logic [STAT_W-1:0]          stat_mispred
`endif
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;
   localparam int FW = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;

   typedef enum logic {RUN, FLUSH} state_t;

   state_t          state, state_n;
   logic [FW-1:0]   flush_cnt, flush_cnt_n;
   logic [DEPTH-1:0] q;
   logic [PW-1:0]   head, tail;
   logic            push, pop, head_pred, mis_now;

`ifndef BRU_STATS_EN
   // STAT_W only sizes the statistics counters; this empty block keeps the
   // parameter referenced when they are compiled out.
   if (STAT_W < 1) begin : g_stat_w_unused
   end
`endif

   // Handshake decisions use start-of-cycle state only.
   always_comb begin
      pred_ready = (state == RUN) && (count < CW'(DEPTH));
      push       = pred_valid && pred_ready;
      pop        = res_valid && (count != '0);
      head_pred  = q[head];
      mis_now    = pop && (head_pred != res_taken);
   end

   always_comb begin
      state_n     = state;
      flush_cnt_n = flush_cnt;
      case (state)
         RUN: ;
         FLUSH: begin
            if (flush_cnt == '0) state_n = RUN;
            else                 flush_cnt_n = flush_cnt - 1'b1;
         end
         default: state_n = RUN;
      endcase
      // A mispredict always (re)starts the full flush window.
      if (mis_now) begin
         state_n     = FLUSH;
         flush_cnt_n = FW'(FLUSH_CYCLES - 1);
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state         <= RUN;
         flush_cnt     <= '0;
         q             <= '0;
         head          <= '0;
         tail          <= '0;
         count         <= '0;
         branch        <= 1'b0;
         taken         <= 1'b0;
         mispredict    <= 1'b0;
         err_underflow <= 1'b0;
      end else begin
         state      <= state_n;
         flush_cnt  <= flush_cnt_n;
         branch     <= pop;
         mispredict <= mis_now;
         // taken holds the last update direction between pulses.
         if (pop) taken <= res_taken;
         if (res_valid && (count == '0)) err_underflow <= 1'b1;

         if (mis_now) begin
            // Everything younger than the mispredicted branch is wrong-path,
            // including a prediction arriving on this very edge.
            head  <= '0;
            tail  <= '0;
            count <= '0;
         end else begin
            if (push) begin
               q[tail] <= pred_taken;
               tail    <= tail + 1'b1;
            end
            if (pop) head <= head + 1'b1;
            count <= count + CW'(push) - CW'(pop);
         end
      end
   end

`ifdef BRU_STATS_EN
   always_ff @(posedge clk) begin
      if (reset) begin
         stat_branches <= '0;
         stat_mispred  <= '0;
      end else begin
         if (pop && (stat_branches != '1))    stat_branches <= stat_branches + 1'b1;
         if (mis_now && (stat_mispred != '1)) stat_mispred  <= stat_mispred + 1'b1;
      end
   end
`endif

endmodule

// File: tb/tb_branch_resolve_unit.sv
// tb/tb_branch_resolve_unit.sv - directed self-checking bench for branch_resolve_unit

module tb_branch_resolve_unit;

   logic       clk = 1'b0;
   logic       reset;
   logic       pred_valid, pred_taken, pred_ready;
   logic       res_valid, res_taken;
   logic       branch, taken, mispredict;
   logic [2:0] count;
   logic       err_underflow;
`ifdef BRU_STATS_EN
   logic [3:0] stat_branches, stat_mispred;
`endif

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   branch_resolve_unit #(.DEPTH(4), .FLUSH_CYCLES(2), .STAT_W(4)) dut (
      .clk(clk),
      .reset(reset),
      .pred_valid(pred_valid),
      .pred_taken(pred_taken),
      .pred_ready(pred_ready),
      .res_valid(res_valid),
      .res_taken(res_taken),
      .branch(branch),
      .taken(taken),
      .mispredict(mispredict),
      .count(count),
      .err_underflow(err_underflow)
`ifdef BRU_STATS_EN
      ,
      .stat_branches(stat_branches),
      .stat_mispred(stat_mispred)
`endif
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      pred_valid = 1'b0; pred_taken = 1'b0;
      res_valid  = 1'b0; res_taken  = 1'b0;
      reset = 1'b1;
      tick();
      tick();
      reset = 1'b0;
   endtask

   task automatic test_reset();
      do_reset();
      checks++; if (count !== 3'd0) begin errors++; $display("FAIL reset_count got=%0d exp=0", count); end
      checks++; if (pred_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got=%b exp=1", pred_ready); end
      checks++; if ({branch, taken, mispredict} !== 3'b000) begin errors++; $display("FAIL reset_pulses got=%b exp=000", {branch, taken, mispredict}); end
      checks++; if (err_underflow !== 1'b0) begin errors++; $display("FAIL reset_err got=%b exp=0", err_underflow); end
   endtask

   task automatic test_push();
      logic [2:0] dirs;
      dirs = 3'b101;
      do_reset();
      for (int i = 0; i < 3; i++) begin
         pred_valid = 1'b1; pred_taken = dirs[i];
         tick();
         checks++; if (count !== 3'(i + 1)) begin errors++; $display("FAIL push_count[%0d] got=%0d exp=%0d", i, count, i + 1); end
         checks++; if (branch !== 1'b0) begin errors++; $display("FAIL push_branch[%0d] got=%b exp=0", i, branch); end
      end
      pred_valid = 1'b0;
      checks++; if (pred_ready !== 1'b1) begin errors++; $display("FAIL push_ready got=%b exp=1", pred_ready); end
   endtask

   task automatic test_resolve();
      do_reset();
      pred_valid = 1'b1; pred_taken = 1'b1; tick();
      pred_taken = 1'b0; tick();
      pred_valid = 1'b0;
      checks++; if (count !== 3'd2) begin errors++; $display("FAIL resolve_count0 got=%0d exp=2", count); end
      res_valid = 1'b1; res_taken = 1'b1; tick();
      checks++; if ({branch, taken, mispredict} !== 3'b110) begin errors++; $display("FAIL resolve_first got=%b exp=110", {branch, taken, mispredict}); end
      checks++; if (count !== 3'd1) begin errors++; $display("FAIL resolve_count1 got=%0d exp=1", count); end
      res_taken = 1'b0; tick();
      checks++; if ({branch, taken, mispredict} !== 3'b100) begin errors++; $display("FAIL resolve_second got=%b exp=100", {branch, taken, mispredict}); end
      checks++; if (count !== 3'd0) begin errors++; $display("FAIL resolve_count2 got=%0d exp=0", count); end
      res_valid = 1'b0; tick();
      checks++; if (branch !== 1'b0) begin errors++; $display("FAIL resolve_pulse_len got=%b exp=0", branch); end
      checks++; if (err_underflow !== 1'b0) begin errors++; $display("FAIL resolve_err got=%b exp=0", err_underflow); end
   endtask

   task automatic test_full();
      do_reset();
      pred_valid = 1'b1; pred_taken = 1'b1;
      for (int i = 0; i < 4; i++) tick();
      checks++; if (count !== 3'd4) begin errors++; $display("FAIL full_count got=%0d exp=4", count); end
      checks++; if (pred_ready !== 1'b0) begin errors++; $display("FAIL full_ready got=%b exp=0", pred_ready); end
      res_valid = 1'b1; res_taken = 1'b1; tick();
      pred_valid = 1'b0; res_valid = 1'b0;
      checks++; if (count !== 3'd3) begin errors++; $display("FAIL full_pushpop_count got=%0d exp=3", count); end
      checks++; if ({branch, mispredict} !== 2'b10) begin errors++; $display("FAIL full_pushpop_pulse got=%b exp=10", {branch, mispredict}); end
      checks++; if (pred_ready !== 1'b1) begin errors++; $display("FAIL full_ready_after got=%b exp=1", pred_ready); end
   endtask

   task automatic test_mispredict();
      do_reset();
      pred_valid = 1'b1; pred_taken = 1'b1;
      for (int i = 0; i < 3; i++) tick();
      // Resolve wrong while a fourth prediction is offered: it must be discarded.
      res_valid = 1'b1; res_taken = 1'b0; tick();
      pred_valid = 1'b0; res_valid = 1'b0;
      checks++; if ({branch, taken, mispredict} !== 3'b101) begin errors++; $display("FAIL mis_pulse got=%b exp=101", {branch, taken, mispredict}); end
      checks++; if (count !== 3'd0) begin errors++; $display("FAIL mis_count got=%0d exp=0", count); end
      checks++; if (pred_ready !== 1'b0) begin errors++; $display("FAIL mis_ready0 got=%b exp=0", pred_ready); end
      pred_valid = 1'b1; tick();
      checks++; if (pred_ready !== 1'b0) begin errors++; $display("FAIL mis_ready1 got=%b exp=0", pred_ready); end
      checks++; if ({branch, taken, mispredict} !== 3'b000) begin errors++; $display("FAIL mis_pulse_end got=%b exp=000", {branch, taken, mispredict}); end
      checks++; if (count !== 3'd0) begin errors++; $display("FAIL mis_flush_push got=%0d exp=0", count); end
      pred_valid = 1'b0; tick();
      checks++; if (pred_ready !== 1'b1) begin errors++; $display("FAIL mis_ready2 got=%b exp=1", pred_ready); end
   endtask

   task automatic test_back_to_back();
      logic [7:0] pat;
      pat = 8'b1011_0100;
      do_reset();
      pred_valid = 1'b1; pred_taken = pat[0]; tick();
      // Steady push+pop at occupancy 1; pointers wrap past DEPTH.
      for (int i = 0; i < 7; i++) begin
         pred_taken = pat[i + 1];
         res_valid  = 1'b1; res_taken = pat[i];
         tick();
         checks++; if ({branch, taken, mispredict} !== {1'b1, pat[i], 1'b0}) begin errors++; $display("FAIL b2b_pulse[%0d] got=%b exp=%b", i, {branch, taken, mispredict}, {1'b1, pat[i], 1'b0}); end
         checks++; if (count !== 3'd1) begin errors++; $display("FAIL b2b_count[%0d] got=%0d exp=1", i, count); end
      end
      pred_valid = 1'b0; res_valid = 1'b0;
   endtask

   task automatic test_underflow();
      do_reset();
      res_valid = 1'b1; res_taken = 1'b1; tick();
      res_valid = 1'b0;
      checks++; if (branch !== 1'b0) begin errors++; $display("FAIL uf_branch got=%b exp=0", branch); end
      checks++; if (err_underflow !== 1'b1) begin errors++; $display("FAIL uf_err got=%b exp=1", err_underflow); end
      tick(); tick();
      checks++; if (err_underflow !== 1'b1) begin errors++; $display("FAIL uf_sticky got=%b exp=1", err_underflow); end
      do_reset();
      checks++; if (err_underflow !== 1'b0) begin errors++; $display("FAIL uf_reset got=%b exp=0", err_underflow); end
      pred_valid = 1'b1; pred_taken = 1'b1; res_valid = 1'b1; tick();
      pred_valid = 1'b0; res_valid = 1'b0;
      checks++; if (count !== 3'd1) begin errors++; $display("FAIL uf_push_count got=%0d exp=1", count); end
      checks++; if ({branch, err_underflow} !== 2'b01) begin errors++; $display("FAIL uf_push_flags got=%b exp=01", {branch, err_underflow}); end
   endtask

`ifdef BRU_STATS_EN
   task automatic test_stats();
      do_reset();
      for (int i = 0; i < 20; i++) begin
         pred_valid = 1'b1; pred_taken = 1'b1; tick();
         pred_valid = 1'b0; res_valid = 1'b1; res_taken = 1'b0; tick();
         res_valid = 1'b0; tick(); tick();
         if (i == 2) begin
            checks++; if ({stat_branches, stat_mispred} !== {4'd3, 4'd3}) begin errors++; $display("FAIL stats_mid got=%0d/%0d exp=3/3", stat_branches, stat_mispred); end
         end
      end
      checks++; if (stat_branches !== 4'd15) begin errors++; $display("FAIL stats_br_sat got=%0d exp=15", stat_branches); end
      checks++; if (stat_mispred !== 4'd15) begin errors++; $display("FAIL stats_mp_sat got=%0d exp=15", stat_mispred); end
      do_reset();
      checks++; if ({stat_branches, stat_mispred} !== 8'd0) begin errors++; $display("FAIL stats_reset got=%0d/%0d exp=0/0", stat_branches, stat_mispred); end
   endtask
`endif

   initial begin
      test_reset();
      test_push();
      test_resolve();
      test_full();
      test_mispredict();
      test_back_to_back();
      test_underflow();
`ifdef BRU_STATS_EN
      test_stats();
`endif
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
